usb_in_arbiter: RTL and testbench
=================================

USB_IN_ARBITER -- requirements
Module: usb_in_arbiter

Interface
REQ-001 SHALL have parameter A_DEPTH, 8, user-byte FIFO depth (power of two).
REQ-002 SHALL have parameter B_DEPTH, 4, entropy-byte FIFO depth (power of two).
REQ-003 SHALL have parameter MAX_BURST, 8, max payload bytes per burst (1..8; matches IN bulk max packet size).
REQ-004 SHALL have ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: configured_i  in  1  USB device configured; a_data_i  in  8  user byte; a_valid_i  in  1  user byte valid; a_ready_o  out  1  user FIFO not full.
REQ-006 SHALL have ports: env_bit_i  in  1  entropy bit; env_valid_i  in  1  entropy bit strobe; ovf_clr_i  in  1  clear overflow flag; ovf_o  out  1  sticky entropy overflow.
REQ-007 SHALL have ports: in_data_o  out  8  byte to CDC IN endpoint; in_valid_o  out  1  byte valid; in_ready_i  in  1  CDC IN endpoint accepts.

Function
REQ-008 SHALL push a_data_i into FIFO A when a_valid_i && a_ready_o; a_ready_o = FIFO A not full.
REQ-009 SHALL shift env_bit_i into an 8-bit packer LSB-first-in (first bit ends in bit 7) on each env_valid_i while configured_i=1.
REQ-010 SHALL, on the 8th bit, push the packed byte into FIFO B in the same cycle; if FIFO B is full the byte is dropped and ovf_o set.
REQ-011 SHALL clear ovf_o on ovf_clr_i; a simultaneous set wins.
REQ-012 SHALL allow simultaneous push and pop on each FIFO, including at full (pop frees a slot, push accepted only if not full before the edge).
REQ-013 SHALL run FSM IDLE -> HDR -> DATA -> IDLE.
REQ-014 IDLE: if configured_i and either FIFO non-empty, grant one source, latch len = min(count, MAX_BURST), go HDR.
REQ-015 Arbitration: both non-empty -> grant source not granted last; one non-empty -> grant it; last_src resets to B (A wins first tie).
REQ-016 HDR: in_data_o = {src, 4'b1010, len-1}, src 0=A, 1=B (e.g. A len 8 = 0x57, B len 3 = 0xD2); on in_ready_i go DATA.
REQ-017 DATA: in_data_o = granted FIFO head; each in_valid_o && in_ready_i pops one byte, decrements remaining; after the len-th pop go IDLE.
REQ-018 in_valid_o SHALL be 1 exactly in HDR and DATA; in_data_o SHALL hold stable while in_valid_o && !in_ready_i.
REQ-019 Latency: byte accepted at edge N on an idle, empty arbiter -> header valid after edge N+1, payload after the header handshake.
REQ-020 Bytes arriving during a burst SHALL NOT extend the latched len.
REQ-021 configured_i=0 SHALL force IDLE next edge (abort, unpopped bytes stay in FIFO), flush FIFO B, clear the packer, hold FIFO A contents.
REQ-022 in_valid_o SHALL be 0 in the cycle after configured_i falls.

Reset
REQ-023 rst_n low SHALL asynchronously set: state IDLE, FIFOs empty, packer and bit count 0, last_src=B, ovf_o=0, in_valid_o=0, in_data_o=0, a_ready_o=1.
REQ-024 Reset release SHALL take effect on the first clk rising edge with rst_n high; no other reset source.

Structure
REQ-025 Shared package usb_arb_pkg SHALL hold the FSM state enum, the source enum (SRC_A/SRC_B), header sync constant 4'b1010 and header build function.
REQ-026 The two FIFOs SHALL be instances of one sub-module stream_fifo (parameterised width, depth; push/pop/full/empty/count).
REQ-027 Packer, ovf flag and FSM SHALL reside in usb_in_arbiter.

Verification
REQ-028 Push 3 user bytes 0x11,0x22,0x33, in_ready_i=1 -> out 0x52,0x11,0x22,0x33, then in_valid_o=0.
REQ-029 Fill A with 10 bytes -> bursts 0x57+8 bytes, then 0x51+2 bytes; a_ready_o=0 exactly while A holds 8.
REQ-030 A holds 2 bytes, FIFO B holds 1 byte, both waiting -> order A burst (0x51), B burst (0xD0), alternating thereafter.
REQ-031 Feed 48 entropy bits with in_ready_i=0 -> FIFO B full after 32, 5th and 6th bytes dropped, ovf_o=1 until ovf_clr_i pulse.
REQ-032 Drop configured_i after header handshake, 2 payload bytes popped of 5 -> in_valid_o=0 next cycle, FIFO A still holds 3; on reconfigure header 0x52 follows.
REQ-033 Assert rst_n=0 mid-DATA asynchronously -> in_valid_o=0 before next clk edge; all REQ-023 values hold.

Source files
------------

// File: rtl/usb_arb_pkg.sv
// Shared types and header helpers for the USB IN-endpoint arbiter.
// The header byte is {source, sync nibble, burst length - 1}.
package usb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData
    } arb_state_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    localparam logic [3:0] HDR_SYNC = 4'b1010;

    function automatic logic [7:0] hdr_byte(input src_e src, input logic [3:0] len);
        logic [2:0] len_m1;
        len_m1 = 3'(len - 4'd1);
        return {src, HDR_SYNC, len_m1};
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Circular-buffer FIFO with occupancy count and synchronous flush.
// Push is accepted only if not full before the edge, even when a pop frees a slot.
module stream_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_en, pop_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_en && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end

endmodule

// File: rtl/usb_in_arbiter.sv
// Merges user bytes (FIFO A) and packed entropy bytes (FIFO B) into headed
// bursts on a single CDC IN byte stream, alternating sources when both wait.
module usb_in_arbiter
    import usb_arb_pkg::*;
#(
    parameter int unsigned A_DEPTH   = 8,
    parameter int unsigned B_DEPTH   = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       configured_i,
    input  logic [7:0] a_data_i,
    input  logic       a_valid_i,
    output logic       a_ready_o,
    input  logic       env_bit_i,
    input  logic       env_valid_i,
    input  logic       ovf_clr_i,
    output logic       ovf_o,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    input  logic       in_ready_i
);

    localparam int unsigned ACW = $clog2(A_DEPTH) + 1;
    localparam int unsigned BCW = $clog2(B_DEPTH) + 1;

    logic [7:0]     a_head, b_head, pack_q, pack_next;
    logic           a_full, a_empty, b_full, b_empty;
    logic [ACW-1:0] a_count;
    logic [BCW-1:0] b_count;
    logic           a_pop, b_pop, b_push, env_take, ovf_q;
    logic [2:0]     bit_cnt_q;

    arb_state_e state_q, state_d;
    src_e       src_q, src_d, last_q, last_d, grant;
    logic [3:0] len_q, len_d, rem_q, rem_d, grant_len;
    logic [7:0] sel_cnt;

    stream_fifo #(.WIDTH(8), .DEPTH(A_DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (a_valid_i),
        .wdata_i (a_data_i),
        .pop_i   (a_pop),
        .flush_i (1'b0),
        .rdata_o (a_head),
        .full_o  (a_full),
        .empty_o (a_empty),
        .count_o (a_count)
    );

    stream_fifo #(.WIDTH(8), .DEPTH(B_DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (b_push),
        .wdata_i (pack_next),
        .pop_i   (b_pop),
        .flush_i (!configured_i),
        .rdata_o (b_head),
        .full_o  (b_full),
        .empty_o (b_empty),
        .count_o (b_count)
    );

    assign a_ready_o = !a_full;
    assign ovf_o     = ovf_q;

    // First bit in ends up in bit 7 of the packed byte.
    assign env_take  = env_valid_i && configured_i;
    assign pack_next = {pack_q[6:0], env_bit_i};
    assign b_push    = env_take && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q    <= '0;
            bit_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (!configured_i) begin
                pack_q    <= '0;
                bit_cnt_q <= '0;
            end else if (env_take) begin
                pack_q    <= pack_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (b_push && b_full) ovf_q <= 1'b1;
            else if (ovf_clr_i)   ovf_q <= 1'b0;
        end
    end

    always_comb begin
        if (!a_empty && !b_empty) grant = (last_q == SRC_A) ? SRC_B : SRC_A;
        else                      grant = a_empty ? SRC_B : SRC_A;
        sel_cnt   = (grant == SRC_A) ? 8'(a_count) : 8'(b_count);
        grant_len = (sel_cnt > 8'(MAX_BURST)) ? 4'(MAX_BURST) : sel_cnt[3:0];
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        last_d     = last_q;
        len_d      = len_q;
        rem_d      = rem_q;
        in_valid_o = 1'b0;
        in_data_o  = '0;
        a_pop      = 1'b0;
        b_pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (configured_i && (!a_empty || !b_empty)) begin
                    src_d   = grant;
                    last_d  = grant;
                    len_d   = grant_len;
                    rem_d   = grant_len;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                in_valid_o = 1'b1;
                in_data_o  = hdr_byte(src_q, len_q);
                if (in_ready_i) state_d = StData;
            end
            StData: begin
                in_valid_o = 1'b1;
                in_data_o  = (src_q == SRC_A) ? a_head : b_head;
                if (in_ready_i) begin
                    a_pop = (src_q == SRC_A);
                    b_pop = (src_q == SRC_B);
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Losing configuration aborts any burst; unpopped bytes stay queued.
        if (!configured_i) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_q   <= SRC_A;
            last_q  <= SRC_B;
            len_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            last_q  <= last_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Scoreboard bench for usb_in_arbiter: stimulus queues hand-computed output
// bytes, an independent monitor pops and compares on every IN handshake.
module tb_usb_in_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       configured_i = 1'b0;
    logic [7:0] a_data_i = '0;
    logic       a_valid_i = 1'b0;
    logic       a_ready_o;
    logic       env_bit_i = 1'b0;
    logic       env_valid_i = 1'b0;
    logic       ovf_clr_i = 1'b0;
    logic       ovf_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always #5 clk = ~clk;

    usb_in_arbiter #(.A_DEPTH(8), .B_DEPTH(4), .MAX_BURST(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .configured_i (configured_i),
        .a_data_i     (a_data_i),
        .a_valid_i    (a_valid_i),
        .a_ready_o    (a_ready_o),
        .env_bit_i    (env_bit_i),
        .env_valid_i  (env_valid_i),
        .ovf_clr_i    (ovf_clr_i),
        .ovf_o        (ovf_o),
        .in_data_o    (in_data_o),
        .in_valid_o   (in_valid_o),
        .in_ready_i   (in_ready_i)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted byte and the hold-while-stalled rule.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && in_valid_o) check("hold_stable", in_data_o, prev_data);
            if (in_valid_o && in_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got 0x%02h expected none", in_data_o);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("in_data", in_data_o, exp_byte);
                end
            end
            prev_stall = in_valid_o && !in_ready_i;
            prev_data  = in_data_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        configured_i = 1'b0;
        a_valid_i = 1'b0;
        env_valid_i = 1'b0;
        ovf_clr_i = 1'b0;
        in_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic push_a(input logic [7:0] b);
        bit done = 0;
        a_data_i = b;
        a_valid_i = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (a_ready_o) begin
                step();
                done = 1;
                break;
            end
            step();
        end
        a_valid_i = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: got a_ready=0 expected 1 for byte 0x%02h", b);
        end
    endtask

    task automatic feed_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            env_bit_i = b[i];
            env_valid_i = 1'b1;
            step();
        end
        env_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 50 && !in_valid_o; k++) step();
        check(name, 8'(in_valid_o), 8'h01);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) step();
        check(name, 8'(exp_q.size()), 8'h00);
        repeat (2) step();
        check({name, "_idle"}, 8'(in_valid_o), 8'h00);
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    initial begin
        #2;
        check("rst_valid", 8'(in_valid_o), 8'h00);
        check("rst_data", in_data_o, 8'h00);
        check("rst_a_ready", 8'(a_ready_o), 8'h01);
        check("rst_ovf", 8'(ovf_o), 8'h00);
        do_reset();

        // Three user bytes -> header 0x52 then payload.
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        push_exp(8'h52); push_exp(8'h11); push_exp(8'h22); push_exp(8'h33);
        configured_i = 1'b1;
        in_ready_i = 1'b1;
        wait_drain("three_bytes");

        // Ten user bytes: full burst of 8, then 2.
        do_reset();
        for (int i = 0; i < 7; i++) push_a(8'h40 + 8'(i));
        check("a_ready_at_7", 8'(a_ready_o), 8'h01);
        push_a(8'h47);
        check("a_ready_at_8", 8'(a_ready_o), 8'h00);
        push_exp(8'h57);
        for (int i = 0; i < 8; i++) push_exp(8'h40 + 8'(i));
        push_exp(8'h51); push_exp(8'h48); push_exp(8'h49);
        configured_i = 1'b1;
        in_ready_i = 1'b1;
        push_a(8'h48);
        push_a(8'h49);
        wait_drain("ten_bytes");

        // Alternation: B burst holds the bus while A and B both queue.
        do_reset();
        configured_i = 1'b1;
        feed_byte(8'hA5);
        push_a(8'h61); push_a(8'h62);
        feed_byte(8'h3C);
        push_exp(8'hD0); push_exp(8'hA5);
        push_exp(8'h51); push_exp(8'h61); push_exp(8'h62);
        push_exp(8'hD0); push_exp(8'h3C);
        in_ready_i = 1'b1;
        wait_drain("alternate");

        // Entropy overflow: 6 bytes into a 4-deep FIFO with the bus stalled.
        do_reset();
        configured_i = 1'b1;
        feed_byte(8'h81); feed_byte(8'h82); feed_byte(8'h83); feed_byte(8'h84);
        check("ovf_after_32", 8'(ovf_o), 8'h00);
        feed_byte(8'h85);
        check("ovf_after_40", 8'(ovf_o), 8'h01);
        feed_byte(8'h86);
        check("ovf_after_48", 8'(ovf_o), 8'h01);
        ovf_clr_i = 1'b1;
        step();
        ovf_clr_i = 1'b0;
        check("ovf_cleared", 8'(ovf_o), 8'h00);
        push_exp(8'hD0); push_exp(8'h81);
        push_exp(8'hD2); push_exp(8'h82); push_exp(8'h83); push_exp(8'h84);
        in_ready_i = 1'b1;
        wait_drain("entropy");

        // Abort mid-burst by dropping configuration, then resume.
        do_reset();
        for (int i = 0; i < 5; i++) push_a(8'h91 + 8'(i));
        push_exp(8'h54); push_exp(8'h91); push_exp(8'h92);
        configured_i = 1'b1;
        wait_valid("abort_hdr_valid");
        in_ready_i = 1'b1;
        repeat (3) step();
        in_ready_i = 1'b0;
        configured_i = 1'b0;
        step();
        check("abort_valid_low", 8'(in_valid_o), 8'h00);
        check("abort_pops", 8'(exp_q.size()), 8'h00);
        push_exp(8'h52); push_exp(8'h93); push_exp(8'h94); push_exp(8'h95);
        configured_i = 1'b1;
        in_ready_i = 1'b1;
        wait_drain("resume");

        // Asynchronous reset in the middle of a payload.
        do_reset();
        for (int i = 0; i < 4; i++) push_a(8'hC1 + 8'(i));
        push_exp(8'h53); push_exp(8'hC1); push_exp(8'hC2); push_exp(8'hC3); push_exp(8'hC4);
        configured_i = 1'b1;
        in_ready_i = 1'b1;
        wait_valid("rst_mid_hdr_valid");
        step();
        step();
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_valid", 8'(in_valid_o), 8'h00);
        check("rst_mid_data", in_data_o, 8'h00);
        check("rst_mid_a_ready", 8'(a_ready_o), 8'h01);
        check("rst_mid_ovf", 8'(ovf_o), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        check("rst_mid_fifo_empty", 8'(in_valid_o), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
